e203_exu_regfile_sb: RTL and testbench

Parametrised general-purpose register file for the EXU with a configurable number of read ports, two write-back ports and a per-register pending-write scoreboard. It sits between the decode/dispatch stage and the write-back arbiter. Dispatch reads operands and checks hazards in one place. Long-latency units (LSU, MULDIV) mark their destination busy at issue and clear it at write-back.

---
 rtl/e203_exu_regfile_sb.sv | 81 ++++++++
 tb/tb_e203_exu_regfile_sb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_regfile_sb.sv
// e203_exu_regfile_sb: EXU general-purpose register file with a per-register pending-write scoreboard.
// Optional E203_REGFILE_BYPASS_EN forwards same-cycle write-back data and busy clears to the read ports.
module e203_exu_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int RF_NUM   = 32,
    parameter int IDXW     = $clog2(RF_NUM),
    parameter int RD_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RD_PORTS*IDXW-1:0] rd_idx,
    output logic [RD_PORTS*XLEN-1:0] rd_dat,
    output logic [RD_PORTS-1:0]      rd_busy,
    input  logic                     iss_vld,
    input  logic [IDXW-1:0]          iss_idx,
    input  logic                     wb0_vld,
    input  logic [IDXW-1:0]          wb0_idx,
    input  logic [XLEN-1:0]          wb0_dat,
    input  logic                     wb1_vld,
    input  logic [IDXW-1:0]          wb1_idx,
    input  logic [XLEN-1:0]          wb1_dat,
    input  logic                     flush,
    output logic [IDXW:0]            busy_cnt,
    output logic [XLEN-1:0]          x1_r
);
    logic [XLEN-1:0]   rf      [1:RF_NUM-1];
    logic [XLEN-1:0]   rf_view [RF_NUM];
    logic [IDXW-1:0]   ridx    [RD_PORTS];
    logic [RF_NUM-1:0] busy, busy_nxt;
    logic [IDXW:0]     cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < RF_NUM; i++) rf[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 1; i < RF_NUM; i++)
                if (wb1_vld && wb1_idx == IDXW'(i)) rf[i] <= wb1_dat;
                else if (wb0_vld && wb0_idx == IDXW'(i)) rf[i] <= wb0_dat;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A same-cycle issue re-arms the bit over a wb0 clear; flush overrides both.
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int i = 1; i < RF_NUM; i++) begin
            busy_nxt[i] = !flush && ((iss_vld && iss_idx == IDXW'(i)) ||
                                     (busy[i] && !(wb0_vld && wb0_idx == IDXW'(i))));
            cnt_nxt     = cnt_nxt + (IDXW+1)'(busy_nxt[i]);
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < RF_NUM; i++) rf_view[i] = rf[i];
    end

    always_comb begin
        rd_dat  = '0;
        rd_busy = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            ridx[p] = rd_idx[p*IDXW +: IDXW];
`ifdef E203_REGFILE_BYPASS_EN
            rd_dat[p*XLEN +: XLEN] = (ridx[p] == '0) ? '0 :
                                     (wb1_vld && wb1_idx == ridx[p]) ? wb1_dat :
                                     (wb0_vld && wb0_idx == ridx[p]) ? wb0_dat : rf_view[ridx[p]];
            rd_busy[p] = busy[ridx[p]] && !(wb0_vld && wb0_idx == ridx[p] &&
                                            !(iss_vld && iss_idx == ridx[p]));
`else
            rd_dat[p*XLEN +: XLEN] = rf_view[ridx[p]];
            rd_busy[p]             = busy[ridx[p]];
`endif
        end
    end

    assign x1_r = rf[1];
endmodule

// File: tb/tb_e203_exu_regfile_sb.sv
// tb_e203_exu_regfile_sb: scoreboard bench; directed test-plan cases plus randomized traffic
// checked against an array-based reference model.
module tb_e203_exu_regfile_sb;
    localparam int XLEN = 32, RF_NUM = 32, IDXW = $clog2(RF_NUM), RD_PORTS = 3;

    typedef struct packed {
        logic [RD_PORTS*XLEN-1:0] dat;
        logic [RD_PORTS-1:0]      busy;
        logic [IDXW:0]            cnt;
        logic [XLEN-1:0]          x1;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [RD_PORTS*IDXW-1:0] rd_idx = '0;
    logic [RD_PORTS*XLEN-1:0] rd_dat;
    logic [RD_PORTS-1:0]      rd_busy;
    logic iss_vld = 1'b0, wb0_vld = 1'b0, wb1_vld = 1'b0, flush = 1'b0;
    logic [IDXW-1:0] iss_idx = '0, wb0_idx = '0, wb1_idx = '0;
    logic [XLEN-1:0] wb0_dat = '0, wb1_dat = '0;
    logic [IDXW:0]   busy_cnt;
    logic [XLEN-1:0] x1_r;

    always #5 clk = ~clk;

    e203_exu_regfile_sb #(.XLEN(XLEN), .RF_NUM(RF_NUM), .IDXW(IDXW), .RD_PORTS(RD_PORTS)) dut (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat), .rd_busy(rd_busy),
        .iss_vld(iss_vld), .iss_idx(iss_idx),
        .wb0_vld(wb0_vld), .wb0_idx(wb0_idx), .wb0_dat(wb0_dat),
        .wb1_vld(wb1_vld), .wb1_idx(wb1_idx), .wb1_dat(wb1_dat),
        .flush(flush), .busy_cnt(busy_cnt), .x1_r(x1_r)
    );

    logic [XLEN-1:0] m_rf [RF_NUM];
    bit              m_busy [RF_NUM];
    exp_t            exp_q [$];
    exp_t            mon_e;
    int              checks = 0, failures = 0;

    task automatic chk(input string name, input logic [RD_PORTS*XLEN-1:0] act, input logic [RD_PORTS*XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < RF_NUM; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 0;
        end
    endtask

    // Expected outputs for the current cycle from the model state and the live inputs.
    function automatic exp_t model_out();
        exp_t e;
        int   n = 0;
        e = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            int idx = int'(rd_idx[p*IDXW +: IDXW]);
            logic [XLEN-1:0] v = m_rf[idx];
            bit b = m_busy[idx];
`ifdef E203_REGFILE_BYPASS_EN
            if (idx != 0) begin
                if (wb0_vld && int'(wb0_idx) == idx) v = wb0_dat;
                if (wb1_vld && int'(wb1_idx) == idx) v = wb1_dat;
                if (wb0_vld && int'(wb0_idx) == idx && !(iss_vld && int'(iss_idx) == idx)) b = 0;
            end
`endif
            e.dat[p*XLEN +: XLEN] = v;
            e.busy[p]             = b;
        end
        for (int i = 0; i < RF_NUM; i++) n += int'(m_busy[i]);
        e.cnt = (IDXW+1)'(n);
        e.x1  = m_rf[1];
        return e;
    endfunction

    // Apply the writes and scoreboard updates in priority order; later assignments win.
    task automatic model_update();
        if (wb0_vld) m_rf[wb0_idx] = wb0_dat;
        if (wb1_vld) m_rf[wb1_idx] = wb1_dat;
        m_rf[0] = '0;
        if (wb0_vld) m_busy[wb0_idx] = 0;
        if (iss_vld) m_busy[iss_idx] = 1;
        if (flush) for (int i = 0; i < RF_NUM; i++) m_busy[i] = 0;
        m_busy[0] = 0;
    endtask

    task automatic step(input logic iv, input int ii, input logic w0v, input int w0i, input logic [XLEN-1:0] w0d,
                        input logic w1v, input int w1i, input logic [XLEN-1:0] w1d, input logic fl,
                        input logic [RD_PORTS*IDXW-1:0] ri);
        iss_vld = iv;  iss_idx = IDXW'(ii);
        wb0_vld = w0v; wb0_idx = IDXW'(w0i); wb0_dat = w0d;
        wb1_vld = w1v; wb1_idx = IDXW'(w1i); wb1_dat = w1d;
        flush = fl; rd_idx = ri;
        exp_q.push_back(model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0, '0, 0, '0);
    endtask

    task automatic anchor(input string name, input int idx, input logic [XLEN-1:0] d, input logic b);
        iss_vld = 0; wb0_vld = 0; wb1_vld = 0; flush = 0;
        rd_idx = {RD_PORTS{IDXW'(idx)}};
        #1;
        chk({name, "_dat"}, rd_dat[RD_PORTS*XLEN-1 -: XLEN], d);
        chk({name, "_busy"}, rd_busy[RD_PORTS-1], b);
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, RF_NUM-1));
    endfunction

    always @(negedge clk)
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("rd_dat", rd_dat, mon_e.dat);
            chk("rd_busy", rd_busy, mon_e.busy);
            chk("busy_cnt", busy_cnt, mon_e.cnt);
            chk("x1_r", x1_r, mon_e.x1);
        end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [RD_PORTS*IDXW-1:0] ri;
        m_clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        step(1, 6, 0, 0, '0, 1, 5, 32'h1234, 0, '0);
        step(1, 3, 0, 0, '0, 1, 1, 32'h0BAD, 0, '0);
        anchor("pre_rst_x5", 5, 32'h1234, 0);
        chk("pre_rst_cnt", busy_cnt, 2);
        rst = 1;
        m_clear();
        rd_idx = {RD_PORTS{IDXW'(5)}};
        exp_q.push_back(model_out());
        anchor("rst_x5", 5, '0, 0);
        chk("rst_cnt", busy_cnt, 0);
        chk("rst_x1", x1_r, 0);
        @(posedge clk);
        #1 rst = 0;

        step(0, 0, 1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, '0);
        anchor("coll_x7", 7, 32'h5555, 0);
        step(0, 0, 0, 0, '0, 1, 0, 32'hFFFF, 0, '0);
        anchor("x0_wr", 0, '0, 0);

        step(1, 3, 0, 0, '0, 0, 0, '0, 0, '0);
        anchor("iss_x3", 3, '0, 1);
        chk("iss_cnt", busy_cnt, 1);
        idle();
        step(0, 0, 1, 3, 32'h33, 0, 0, '0, 0, '0);
        anchor("wb0_x3", 3, 32'h33, 0);
        chk("wb0_cnt", busy_cnt, 0);
        step(1, 3, 1, 3, 32'h44, 0, 0, '0, 0, '0);
        anchor("set_clr_x3", 3, 32'h44, 1);
        step(0, 0, 1, 3, 32'h45, 0, 0, '0, 0, '0);

        step(1, 1, 0, 0, '0, 0, 0, '0, 0, '0);
        step(1, 2, 0, 0, '0, 0, 0, '0, 0, '0);
        step(1, 31, 0, 0, '0, 0, 0, '0, 0, '0);
        chk("flush_pre_cnt", busy_cnt, 3);
        step(1, 4, 0, 0, '0, 0, 0, '0, 1, '0);
        anchor("flush_x4", 4, '0, 0);
        chk("flush_cnt", busy_cnt, 0);

        step(1, 9, 0, 0, '0, 1, 9, 32'h1111, 0, '0);
        iss_vld = 0; flush = 0;
        wb0_vld = 1; wb0_idx = IDXW'(9); wb0_dat = 32'hBEEF;
        wb1_vld = 1; wb1_idx = IDXW'(9); wb1_dat = 32'hDEAD;
        rd_idx = {RD_PORTS{IDXW'(9)}};
        exp_q.push_back(model_out());
        #1;
`ifdef E203_REGFILE_BYPASS_EN
        chk("byp_same_dat", rd_dat[XLEN-1:0], 32'hDEAD);
        chk("byp_same_busy", rd_busy[0], 0);
`else
        chk("byp_same_dat", rd_dat[XLEN-1:0], 32'h1111);
        chk("byp_same_busy", rd_busy[0], 1);
`endif
        @(posedge clk);
        model_update();
        #1;
        anchor("byp_next", 9, 32'hDEAD, 0);

        for (int i = 1; i < RF_NUM; i++) step(1, i, 0, 0, '0, 0, 0, '0, 0, '0);
        chk("fill_cnt", busy_cnt, RF_NUM-1);
        idle();

        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < RD_PORTS; p++) ri[p*IDXW +: IDXW] = IDXW'(rnd_idx());
            step($urandom_range(0, 2) != 0, rnd_idx(),
                 $urandom_range(0, 1) == 1, rnd_idx(), XLEN'($urandom),
                 $urandom_range(0, 1) == 1, rnd_idx(), XLEN'($urandom),
                 $urandom_range(0, 39) == 0, ri);
        end
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
